// File: rtl/qcpu_sram_pkg.sv
// Shared types and constants for the QCPU work-SRAM arbiter.
package qcpu_sram_pkg;

  localparam int AW_DEF = 7;
  localparam int DW_DEF = 8;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_EXT = 1'b1
  } port_e;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } access_t;

  function automatic port_e otherPort(input port_e p);
    return (p == PORT_CPU) ? PORT_EXT : PORT_CPU;
  endfunction

endpackage

// File: rtl/qcpu_sram_arb_pick.sv
// Combinational winner select for the two SRAM requesters.
// Build option QCPU_SRAM_ARB_RR_EN selects round-robin instead of fixed priority with starvation guard.
module qcpu_sram_arb_pick
  import qcpu_sram_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef QCPU_SRAM_ARB_RR_EN
  input  port_e      prioPort_i,
`else
  input  logic       starve_i,
`endif
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
`ifdef QCPU_SRAM_ARB_RR_EN
    if (req_i == 2'b11) begin
      gnt_o = (prioPort_i == PORT_EXT) ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
`else
    // Port 1 only beats a requesting port 0 once it has been refused long enough.
    if (req_i[1] && (starve_i || !req_i[0])) begin
      gnt_o = 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end
`endif
  end

endmodule

// File: rtl/qcpu_sram_arbiter.sv
// Shares the single-port work SRAM between the QCPU core (port 0) and DMA/debug (port 1).
// Define QCPU_SRAM_ARB_RR_EN for round-robin; default is fixed priority with a starvation guard.
module qcpu_sram_arbiter
  import qcpu_sram_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_in,
  output logic          sram_gwe,
  input  logic [DW-1:0] sram_out
);

  logic [1:0]    req;
  logic [1:0]    pickGnt;
  logic [1:0]    gnt;
  port_e         winPort;
  logic          selWe;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selWdata;

  logic [AW-1:0] sramAddr_q, sramAddr_d;
  logic [DW-1:0] sramIn_q, sramIn_d;
  logic          sramGwe_q, sramGwe_d;
  logic          tagValid_q, tagValid_d;
  port_e         tagPort_q, tagPort_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  assign req = {m1_req, m0_req};

`ifdef QCPU_SRAM_ARB_RR_EN
  port_e prioPort_q, prioPort_d;

  qcpu_sram_arb_pick uPick (
    .req_i      (req),
    .prioPort_i (prioPort_q),
    .gnt_o      (pickGnt)
  );

  always_comb begin
    prioPort_d = prioPort_q;
    if (|gnt) prioPort_d = otherPort(winPort);
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) prioPort_q <= PORT_CPU;
    else        prioPort_q <= prioPort_d;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] starveCnt_q, starveCnt_d;

  qcpu_sram_arb_pick uPick (
    .req_i    (req),
    .starve_i (starveCnt_q == STARVE_LIM),
    .gnt_o    (pickGnt)
  );

  always_comb begin
    starveCnt_d = '0;
    if (m1_req && !gnt[1]) begin
      starveCnt_d = (starveCnt_q == STARVE_LIM) ? starveCnt_q : starveCnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) starveCnt_q <= '0;
    else        starveCnt_q <= starveCnt_d;
  end
`endif

  // Grants are combinational, so gate them so nothing is offered while reset is held.
  assign gnt      = pickGnt & {2{rst_n}};
  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];
  assign winPort  = gnt[1] ? PORT_EXT : PORT_CPU;
  assign selWe    = gnt[1] ? m1_we    : m0_we;
  assign selAddr  = gnt[1] ? m1_addr  : m0_addr;
  assign selWdata = gnt[1] ? m1_wdata : m0_wdata;

  always_comb begin
    sramAddr_d = sramAddr_q;
    sramIn_d   = sramIn_q;
    sramGwe_d  = 1'b0;
    tagValid_d = 1'b0;
    tagPort_d  = tagPort_q;
    if (|gnt) begin
      sramAddr_d = selAddr;
      sramIn_d   = selWdata;
      sramGwe_d  = selWe;
      tagValid_d = !selWe;
      tagPort_d  = winPort;
    end
  end

  // The SRAM returns data in the cycle its address is driven; the tag says whose read it is.
  always_comb begin
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (tagValid_q) begin
      if (tagPort_q == PORT_EXT) begin
        rvalid_d[1] = 1'b1;
        rdata1_d    = sram_out;
      end else begin
        rvalid_d[0] = 1'b1;
        rdata0_d    = sram_out;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sramAddr_q <= '0;
      sramIn_q   <= '0;
      sramGwe_q  <= 1'b0;
      tagValid_q <= 1'b0;
      tagPort_q  <= PORT_CPU;
      rvalid_q   <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      sramAddr_q <= sramAddr_d;
      sramIn_q   <= sramIn_d;
      sramGwe_q  <= sramGwe_d;
      tagValid_q <= tagValid_d;
      tagPort_q  <= tagPort_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign sram_addr = sramAddr_q;
  assign sram_in   = sramIn_q;
  assign sram_gwe  = sramGwe_q;
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_qcpu_sram_arbiter.sv
// Scoreboard bench for qcpu_sram_arbiter: a reference model predicts grants, SRAM pin activity and read returns.
module tb_qcpu_sram_arbiter;
  import qcpu_sram_pkg::*;

  localparam int STARVE = 4;

  logic       clk_i = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [6:0] m0_addr, m1_addr, sram_addr;
  logic [7:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, sram_in, sram_out;
  logic       m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, sram_gwe;

  qcpu_sram_arbiter #(.AW(7), .DW(8), .STARVE_MAX(STARVE)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_addr(sram_addr), .sram_in(sram_in), .sram_gwe(sram_gwe), .sram_out(sram_out)
  );

  always #5 clk_i = ~clk_i;

  // SRAM macro stand-in: read data follows the driven address, writes land at the clock edge.
  bit [7:0] mem [128];
  assign sram_out = mem[sram_addr];
  always @(posedge clk_i) if (sram_gwe) mem[sram_addr] <= sram_in;

  typedef struct {
    bit       port;
    bit [7:0] data;
    int       due;
  } rdExp_t;

  typedef struct {
    int       due;
    bit       we;
    bit [6:0] addr;
    bit [7:0] wdata;
  } sramExp_t;

  rdExp_t   rdQ[$];
  sramExp_t sramQ[$];
  bit [7:0] refMem [128];
  bit [7:0] lastRdata [2];
  int       cyc = 0;
  int       testsRun = 0;
  int       testsFailed = 0;
  int       refused = 0;
  int       rrPrefer = 0;
  logic [1:0] lastGnt;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic access_t mkAcc(input bit we, input bit [6:0] addr, input bit [7:0] wd);
    access_t a;
    a.we = we; a.addr = addr; a.wdata = wd;
    return a;
  endfunction

  function automatic access_t randAcc();
    bit [6:0] addr;
    addr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
    return mkAcc(1'($urandom_range(0, 1)), addr, 8'($urandom));
  endfunction

  // Reference arbitration: decide the winner from the rules, then apply the access to the model memory.
  task automatic modelStep(input bit r0, input access_t a0, input bit r1, input access_t a1);
    int win = -1;
    access_t acc;
    logic [1:0] expG;
`ifdef QCPU_SRAM_ARB_RR_EN
    if (r0 && r1) win = rrPrefer;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    if (win >= 0) rrPrefer = 1 - win;
`else
    if (r1 && (!r0 || refused >= STARVE)) win = 1;
    else if (r0) win = 0;
    if (r1 && win != 1) refused = (refused >= STARVE) ? STARVE : refused + 1;
    else refused = 0;
`endif
    expG = (win == 0) ? 2'b01 : (win == 1) ? 2'b10 : 2'b00;
    checkOutput("gnt", {m1_gnt, m0_gnt}, expG);
    if (win >= 0) begin
      acc = (win == 1) ? a1 : a0;
      sramQ.push_back('{due: cyc + 1, we: acc.we, addr: acc.addr, wdata: acc.wdata});
      if (acc.we) refMem[acc.addr] = acc.wdata;
      else rdQ.push_back('{port: (win == 1), data: refMem[acc.addr], due: cyc + 2});
    end
  endtask

  task automatic modelReset();
    refused  = 0;
    rrPrefer = 0;
  endtask

  // Drives one cycle of requests (after the active edge) and checks the grant at the falling edge.
  task automatic applyStimulus(input bit r0, input access_t a0, input bit r1, input access_t a1);
    m0_req = r0; m0_we = a0.we; m0_addr = a0.addr; m0_wdata = a0.wdata;
    m1_req = r1; m1_we = a1.we; m1_addr = a1.addr; m1_wdata = a1.wdata;
    @(negedge clk_i);
    modelStep(r0, a0, r1, a1);
    lastGnt = {m1_gnt, m0_gnt};
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, mkAcc(0, 0, 0), 1'b0, mkAcc(0, 0, 0));
  endtask

  task automatic applyReset(input bit r0, input access_t a0);
    rst_n = 1'b0;
    m0_req = r0; m0_we = a0.we; m0_addr = a0.addr; m0_wdata = a0.wdata;
    m1_req = 1'b0;
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    modelReset();
  endtask

  // Monitor: compares SRAM pins and read returns against what the model queued.
  always @(negedge clk_i) begin
    if (!rst_n) begin
      checkOutput("resetOut", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                               sram_addr, sram_in, sram_gwe}, 64'd0);
      rdQ.delete();
      sramQ.delete();
      lastRdata[0] = 8'h00;
      lastRdata[1] = 8'h00;
    end else begin
      if (sramQ.size() > 0 && sramQ[0].due == cyc) begin
        sramExp_t s;
        s = sramQ.pop_front();
        checkOutput("sramGwe", sram_gwe, s.we);
        checkOutput("sramAddr", sram_addr, s.addr);
        if (s.we) checkOutput("sramIn", sram_in, s.wdata);
      end else begin
        checkOutput("sramIdleGwe", sram_gwe, 1'b0);
      end
      if (m0_rvalid || m1_rvalid) begin
        if (rdQ.size() == 0) begin
          checkOutput("rvalidSpurious", {m1_rvalid, m0_rvalid}, 2'b00);
        end else begin
          rdExp_t r;
          r = rdQ.pop_front();
          checkOutput("rvalidPort", {m1_rvalid, m0_rvalid}, r.port ? 2'b10 : 2'b01);
          checkOutput("rvalidCycle", 64'(cyc), 64'(r.due));
          lastRdata[r.port] = r.data;
        end
      end else if (rdQ.size() > 0 && rdQ[0].due <= cyc) begin
        checkOutput("rvalidMissing", {m1_rvalid, m0_rvalid}, rdQ[0].port ? 2'b10 : 2'b01);
        void'(rdQ.pop_front());
      end
      checkOutput("rdata0", m0_rdata, lastRdata[0]);
      checkOutput("rdata1", m1_rdata, lastRdata[1]);
    end
  end

  initial begin
    int m1Count;
    int gntCount;
    bit act0, act1;
    access_t p0, p1;

    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    lastGnt = 2'b00;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    modelReset();

    // Write then read back through port 0.
    applyStimulus(1, mkAcc(1, 7'h12, 8'hA5), 0, mkAcc(0, 0, 0));
    applyStimulus(1, mkAcc(0, 7'h12, 8'h00), 0, mkAcc(0, 0, 0));
    idle(3);

    // Port 1 reads around a port 0 write to the top address.
    applyStimulus(0, mkAcc(0, 0, 0), 1, mkAcc(0, 7'h7F, 8'h00));
    applyStimulus(1, mkAcc(1, 7'h7F, 8'h3C), 0, mkAcc(0, 0, 0));
    applyStimulus(0, mkAcc(0, 0, 0), 1, mkAcc(0, 7'h7F, 8'h00));
    idle(3);

    // Both ports request every cycle.
    m1Count = 0;
    gntCount = 0;
    p0 = mkAcc(0, 7'($urandom_range(0, 15)), 0);
    p1 = mkAcc(0, 7'($urandom_range(0, 15)), 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, p0, 1, p1);
      if (lastGnt != 2'b00) gntCount++;
      if (lastGnt[0]) p0 = mkAcc(0, 7'($urandom_range(0, 15)), 0);
      if (lastGnt[1]) begin
        m1Count++;
        p1 = mkAcc(0, 7'($urandom_range(0, 15)), 0);
      end
    end
`ifdef QCPU_SRAM_ARB_RR_EN
    checkOutput("contendM1Grants", 64'(m1Count), 64'd10);
`else
    checkOutput("contendM1Grants", 64'(m1Count), 64'd4);
`endif
    checkOutput("contendGrantEveryCycle", 64'(gntCount), 64'd20);
    idle(3);

    // Reset one cycle after a read grant: that read must never return.
    applyStimulus(1, mkAcc(0, 7'h12, 8'h00), 0, mkAcc(0, 0, 0));
    applyReset(1, mkAcc(1, 7'h55, 8'h66));
    applyStimulus(1, mkAcc(0, 7'h12, 8'h00), 0, mkAcc(0, 0, 0));
    idle(3);

    // Port 1 pulses a request under port 0 traffic, drops it, then asks again.
    applyStimulus(1, mkAcc(0, 7'h01, 0), 1, mkAcc(1, 7'h20, 8'h77));
    applyStimulus(1, mkAcc(0, 7'h02, 0), 1, mkAcc(1, 7'h20, 8'h77));
    applyStimulus(1, mkAcc(0, 7'h03, 0), 0, mkAcc(0, 0, 0));
    for (int i = 0; i < 5; i++) applyStimulus(1, mkAcc(0, 7'(i), 0), 1, mkAcc(0, 7'h20, 0));
    idle(3);

    // Randomized traffic with occasional abandoned requests.
    act0 = 0; act1 = 0;
    p0 = randAcc(); p1 = randAcc();
    for (int c = 0; c < 400; c++) begin
      if (!act0 && $urandom_range(0, 3) != 0) begin p0 = randAcc(); act0 = 1; end
      else if (act0 && $urandom_range(0, 15) == 0) act0 = 0;
      if (!act1 && $urandom_range(0, 2) == 0) begin p1 = randAcc(); act1 = 1; end
      else if (act1 && $urandom_range(0, 9) == 0) act1 = 0;
      applyStimulus(act0, p0, act1, p1);
      if (lastGnt[0]) act0 = 0;
      if (lastGnt[1]) act1 = 0;
    end
    idle(4);

    checkOutput("queueDrained", 64'(rdQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    testsFailed++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
